// File: rtl/prog_clk_div.sv
// Runtime-programmable clock divider: near-50% duty for any divisor N >= 2,
// one-cycle period tick, and divisor changes that only land on period boundaries.
module prog_clk_div #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_active,
  output logic             load_pending
);

  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO    = WIDTH'(2);
  localparam logic [WIDTH-1:0] DEF    = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DEF_M1 = WIDTH'(DEFAULT_DIV - 1);

  if (DEFAULT_DIV < 2 || DEFAULT_DIV > (2 ** WIDTH) - 1) begin : g_bad_default
    $error("prog_clk_div: DEFAULT_DIV out of range [2, 2^WIDTH-1]");
  end

  // Divisors below 2 cannot form a high and a low phase, so they saturate to 2.
  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] v);
    return (v < TWO) ? TWO : v;
  endfunction

  // Length of the high phase: ceil(N/2), so odd divisors are high one cycle longer.
  function automatic logic [WIDTH-1:0] hi_len(input logic [WIDTH-1:0] n);
    return n - (n >> 1);
  endfunction

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] pend_val;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] next_div;
  logic             wrap;

  // Boundary decode; a load arriving on the wrap edge itself wins over the staged value.
  always_comb begin
    load_val = clamp_div(div_val);
    cnt_inc  = cnt + ONE;
    wrap     = (cnt == div_active - ONE);
    next_div = div_active;
    if (div_load) begin
      next_div = load_val;
    end else if (load_pending) begin
      next_div = pend_val;
    end
  end

  // Counter, divisor and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= DEF_M1;
      div_active   <= DEF;
      pend_val     <= '0;
      load_pending <= 1'b0;
      clk_out      <= 1'b0;
      tick         <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (div_load) begin
        pend_val     <= load_val;
        load_pending <= 1'b1;
      end
      if (en) begin
        if (wrap) begin
          cnt          <= '0;
          tick         <= 1'b1;
          clk_out      <= 1'b1;
          div_active   <= next_div;
          pend_val     <= next_div;
          load_pending <= 1'b0;
        end else begin
          cnt     <= cnt_inc;
          clk_out <= (cnt_inc < hi_len(div_active));
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_clk_div.sv
// Directed bench for prog_clk_div: stimulus pushes expected outputs, a monitor pops and compares.
module tb_prog_clk_div;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] div_val = 8'd0;
  logic       div_load = 1'b0;
  logic       clk_out;
  logic       tick;
  logic [7:0] div_active;
  logic       load_pending;

  prog_clk_div #(.WIDTH(8), .DEFAULT_DIV(6)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div_val(div_val), .div_load(div_load),
    .clk_out(clk_out), .tick(tick), .div_active(div_active), .load_pending(load_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       c;
    logic       t;
    logic [7:0] d;
    logic       p;
  } exp_t;

  exp_t exp_q[$];
  int   id_q[$];
  int   step = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t e;
  int   eid;

  // One clock edge of stimulus plus the outputs expected right after that edge.
  task automatic cyc(input bit r, input bit ena, input bit ld, input logic [7:0] v,
                     input bit ec, input bit et, input logic [7:0] ed, input bit ep);
    exp_t x;
    @(negedge clk);
    rst_n = r; en = ena; div_load = ld; div_val = v;
    x.c = ec; x.t = et; x.d = ed; x.p = ep;
    exp_q.push_back(x);
    id_q.push_back(step);
    step++;
  endtask

  // `cycles` enabled edges of an N-period starting at its wrap edge; optional bypass load of N.
  task automatic period(input int n, input int hi, input int cycles, input bit byp);
    for (int i = 0; i < cycles; i++)
      cyc(1'b1, 1'b1, byp && (i == 0), 8'(n), i < hi, i == 0, 8'(n), 1'b0);
  endtask

  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      eid = id_q.pop_front();
      n_checks++;
      if (clk_out !== e.c || tick !== e.t || div_active !== e.d || load_pending !== e.p) begin
        n_fail++;
        $display("FAIL step %0d: got clk_out=%b tick=%b div_active=%0d load_pending=%b, want clk_out=%b tick=%b div_active=%0d load_pending=%b",
                 eid, clk_out, tick, div_active, load_pending, e.c, e.t, e.d, e.p);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached with %0d expectations queued", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    cyc(0, 0, 0, 0, 0, 0, 6, 0);
    cyc(0, 0, 0, 0, 0, 0, 6, 0);
    // default divisor 6: 1,1,1,0,0,0
    period(6, 3, 6, 0);
    period(6, 3, 6, 0);
    // load 5 at cnt=2; period finishes as 6
    cyc(1, 1, 0, 0, 1, 1, 6, 0);
    cyc(1, 1, 0, 0, 1, 0, 6, 0);
    cyc(1, 1, 1, 5, 1, 0, 6, 1);
    repeat (3) cyc(1, 1, 0, 0, 0, 0, 6, 1);
    period(5, 3, 5, 0);
    period(5, 3, 5, 0);
    // load 9 then 7: last wins
    cyc(1, 1, 0, 0, 1, 1, 5, 0);
    cyc(1, 1, 1, 9, 1, 0, 5, 1);
    cyc(1, 1, 1, 7, 1, 0, 5, 1);
    repeat (2) cyc(1, 1, 0, 0, 0, 0, 5, 1);
    period(7, 4, 7, 0);
    // load 4 on the wrap edge: bypass, never pending
    period(4, 2, 4, 1);
    period(4, 2, 4, 0);
    // load 0 clamps to 2
    cyc(1, 1, 0, 0, 1, 1, 4, 0);
    cyc(1, 1, 1, 0, 1, 0, 4, 1);
    repeat (2) cyc(1, 1, 0, 0, 0, 0, 4, 1);
    period(2, 1, 2, 0);
    period(2, 1, 2, 0);
    // move to 3 by bypass, then load 1 which clamps to 2
    period(3, 2, 1, 1);
    cyc(1, 1, 1, 1, 1, 0, 3, 1);
    cyc(1, 1, 0, 0, 0, 0, 3, 1);
    period(2, 1, 2, 0);
    period(2, 1, 2, 0);
    // N=6, en low 4 cycles mid high phase; a load while disabled still stages
    period(6, 3, 2, 1);
    repeat (3) cyc(1, 0, 0, 0, 1, 0, 6, 0);
    cyc(1, 0, 1, 6, 1, 0, 6, 1);
    cyc(1, 1, 0, 0, 1, 0, 6, 1);
    repeat (3) cyc(1, 1, 0, 0, 0, 0, 6, 1);
    period(6, 3, 6, 0);
    // N=255: 128 high / 127 low, then reset at cnt=100 with a load pending
    period(255, 128, 255, 1);
    period(255, 128, 100, 0);
    cyc(1, 1, 1, 9, 1, 0, 255, 1);
    cyc(0, 1, 0, 0, 0, 0, 6, 0);
    cyc(0, 1, 0, 0, 0, 0, 6, 0);
    // pending 9 discarded; first enabled edge wraps with the default divisor
    period(6, 3, 6, 0);
    period(6, 3, 6, 0);
    // drain
    @(negedge clk);
    div_load = 1'b0;
    repeat (3) @(posedge clk);
    #5;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
